// File: rtl/div_seq_ctrl.sv
// Iterative restoring divider: one subtract-and-shift step per cycle, DATA_W steps per request.
// Define DIV_SIGNED_EN for two's complement operands (adds a one-cycle FIX state for sign correction).
module div_seq_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_by_zero
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    // Handshake: a request is taken on a rising edge where start=1 and ready=1; start at
    // any other time is dropped. done is a single-cycle pulse; results hold until the next accept.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // The partial remainder always stays below the divisor, so W bits hold it between
    // steps; the extra bit exists only inside the trial subtraction.
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvs_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] quotient_q;
    logic [DATA_W-1:0] remainder_q;
    logic              dbz_q;

    logic              accept;
    logic              step;
    logic              fix;
    logic              last_step;
    logic [DATA_W:0]   t_val;
    logic [DATA_W:0]   d_val;
    logic [DATA_W-1:0] rem_n;
    logic [DATA_W-1:0] quo_n;
    logic [DATA_W-1:0] dvd_load;
    logic [DATA_W-1:0] dvs_load;

`ifdef DIV_SIGNED_EN
    logic q_neg_q;
    logic r_neg_q;

    assign dvd_load = dividend[DATA_W-1] ? -dividend : dividend;
    assign dvs_load = divisor[DATA_W-1]  ? -divisor  : divisor;
`else
    assign dvd_load = dividend;
    assign dvs_load = divisor;
`endif

    assign last_step = (cnt_q == CNT_W'(1));

    always_comb begin
        t_val = {rem_q, quo_q[DATA_W-1]};
        d_val = t_val - {1'b0, dvs_q};
        if (!d_val[DATA_W]) begin
            rem_n = d_val[DATA_W-1:0];
            quo_n = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
            rem_n = t_val[DATA_W-1:0];
            quo_n = {quo_q[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = (divisor == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                step = 1'b1;
                if (last_step) begin
`ifdef DIV_SIGNED_EN
                    state_d = FIX;
`else
                    state_d = DONE;
`endif
                end
            end
            FIX: begin
                busy    = 1'b1;
                fix     = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
`endif
        end else begin
            if (accept) begin
                rem_q <= '0;
                quo_q <= dvd_load;
                dvs_q <= dvs_load;
                cnt_q <= CNT_W'(DATA_W);
                dbz_q <= 1'b0;
`ifdef DIV_SIGNED_EN
                q_neg_q <= dividend[DATA_W-1] ^ divisor[DATA_W-1];
                r_neg_q <= dividend[DATA_W-1];
`endif
                // Divide by zero skips iteration and publishes immediately.
                if (divisor == '0) begin
                    quotient_q  <= '1;
                    remainder_q <= dividend;
                    dbz_q       <= 1'b1;
                end
            end
            if (step) begin
                rem_q <= rem_n;
                quo_q <= quo_n;
                cnt_q <= cnt_q - CNT_W'(1);
`ifndef DIV_SIGNED_EN
                if (last_step) begin
                    quotient_q  <= quo_n;
                    remainder_q <= rem_n;
                end
`endif
            end
`ifdef DIV_SIGNED_EN
            if (fix) begin
                quotient_q  <= q_neg_q ? -quo_q : quo_q;
                remainder_q <= r_neg_q ? -rem_q : rem_q;
            end
`endif
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: behavioural model with per-cycle compare plus literal vectors.
// Build with DIV_SIGNED_EN defined to exercise the signed variant.
module tb_div_seq_ctrl;

    localparam int W = 8;
`ifdef DIV_SIGNED_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    div_seq_ctrl #(.DATA_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Reference result {dbz, quotient, remainder} from plain integer arithmetic.
    function automatic logic [2*W:0] ref_result(logic [W-1:0] a, logic [W-1:0] b);
        int sa;
        int sb;
        if (b == '0) return {1'b1, {W{1'b1}}, a};
`ifdef DIV_SIGNED_EN
        sa = $signed(a);
        sb = $signed(b);
`else
        sa = int'(a);
        sb = int'(b);
`endif
        return {1'b0, W'(sa / sb), W'(sa % sb)};
    endfunction

    // Model: accepted requests queue their reference result; it surfaces LAT edges later.
    logic [2*W:0] exp_q[$];
    logic         m_ready;
    logic         m_done;
    logic         m_dbz;
    logic [W-1:0] m_q;
    logic [W-1:0] m_r;
    int           m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 1'b1;
            m_done  <= 1'b0;
            m_dbz   <= 1'b0;
            m_q     <= '0;
            m_r     <= '0;
            m_left  <= 0;
            exp_q.delete();
        end else if (m_done) begin
            m_done  <= 1'b0;
            m_ready <= 1'b1;
        end else if (m_ready) begin
            if (start) begin
                m_ready <= 1'b0;
                m_dbz   <= 1'b0;
                exp_q.push_back(ref_result(dividend, divisor));
                if (divisor == '0) begin
                    m_done <= 1'b1;
                    {m_dbz, m_q, m_r} <= exp_q.pop_front();
                end else begin
                    m_left <= LAT;
                end
            end
        end else if (m_left == 1) begin
            m_done <= 1'b1;
            m_left <= 0;
            {m_dbz, m_q, m_r} <= exp_q.pop_front();
        end else begin
            m_left <= m_left - 1;
        end
    end

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", W'(ready), W'(m_ready));
            check("busy", W'(busy), W'(!m_ready && !m_done));
            check("done", W'(done), W'(m_done));
            check("quotient", quotient, m_q);
            check("remainder", remainder, m_r);
            check("div_by_zero", W'(div_by_zero), W'(m_dbz));
        end
    end

    task automatic issue(logic [W-1:0] a, logic [W-1:0] b);
        int g;
        g = 0;
        @(negedge clk);
        while (!ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!ready) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_ready: got 0 expected 1 at %0t", $time);
        end
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Issue one request, optionally pulse a stray request mid-run, then pin the outcome.
    task automatic run_op(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] eq,
                          logic [W-1:0] er, logic edz, bit junk);
        int lat;
        issue(a, b);
        lat = 1;
        while (!done && lat < 60) begin
            if (junk && lat == 3) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 8'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("latency", W'(lat), W'((b == '0) ? 1 : LAT + 1));
        check("quotient_lit", quotient, eq);
        check("remainder_lit", remainder, er);
        check("dbz_lit", W'(div_by_zero), W'(edz));
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_ready"}, W'(ready), W'(1));
        check({tag, "_busy"}, W'(busy), W'(0));
        check({tag, "_done"}, W'(done), W'(0));
        check({tag, "_quotient"}, quotient, W'(0));
        check({tag, "_remainder"}, remainder, W'(0));
        check({tag, "_dbz"}, W'(div_by_zero), W'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        @(negedge clk);
        check_reset_outputs("reset");
        chk_en = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;

`ifdef DIV_SIGNED_EN
        run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);
        run_op(8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 1'b0);
        run_op(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b0);
        run_op(8'd7, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0);
        run_op(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1'b0);
        run_op(8'd60, 8'd3, 8'd20, 8'd0, 1'b0, 1'b1);
`else
        run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);
        run_op(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1'b0);
        run_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0);
        run_op(8'd3, 8'd10, 8'd0, 8'd3, 1'b0, 1'b0);
        run_op(8'd0, 8'd9, 8'd0, 8'd0, 1'b0, 1'b0);
        run_op(8'd200, 8'd3, 8'd66, 8'd2, 1'b0, 1'b1);
        run_op(8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 1'b0);
`endif

        // Abort mid-operation between E4 and E5.
        issue(8'd100, 8'd7);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        run_op(8'd9, 8'd4, 8'd2, 8'd1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
